slot_stop_ctrl: RTL
===================

# slot_stop_ctrl

Player-side controller for the three-reel slot game: takes the raw push-button, synchronizes and debounces it, and turns each debounced press into a control step. It generates per-reel run enables for the reel counters (reel counter advances on `tick & o_run[i]`), captures each reel's final digit, and flags a win when all three captured digits match. It sits between the board key and the reel counters/display decoders, as the input end of the reel path whose output end drives the 7-segment displays.

## Interface

- `DEBOUNCE_BITS`, default 20: debounce counter width. The key must be stable for 2^DEBOUNCE_BITS consecutive cycles, about 21 ms at 50 MHz.
- `clk`, input, 1: system clock, rising edge.
- `i_rst_n`, input, 1: reset. One clock; reset is asynchronous and active-low.
- `i_key`, input, 1: raw board key, active-low (0 = pressed), asynchronous to `clk`, bouncy.
- `i_reel0`, input, 4: current digit of reel 0 counter (0–9).
- `i_reel1`, input, 4: current digit of reel 1 counter.
- `i_reel2`, input, 4: current digit of reel 2 counter.
- `o_run`, output, 3: bit i high means reel i counter is enabled.
- `o_val0`, output, 4: captured final digit of reel 0.
- `o_val1`, output, 4: captured final digit of reel 1.
- `o_val2`, output, 4: captured final digit of reel 2.
- `o_win`, output, 1: high when the last completed game had all three captured digits equal. Held until the next game starts.
- `o_done`, output, 1: one-cycle pulse when a game completes and `o_win` is valid.

## Operation

- **Synchronizer:** 2 flops on `i_key`. Both flops reset to 1 (released).
- **Debouncer:**
  - The stable level register resets to 1.
  - If the synced key equals the stable level, the counter clears.
  - Otherwise the counter increments.
  - When the counter is all-ones and the key still differs, the stable level takes the synced value and the counter clears.
- **Press pulse:** one cycle when the stable level goes 1→0. Releasing the key produces nothing. Holding the key produces nothing further.
- **FSM** (registered state; `o_run` decoded from state):
  - IDLE, `o_run`=000 (reset state).
    - On press: clear `o_win`, go to SPIN3.
  - SPIN3, `o_run`=111.
    - On press: go to SPIN2 and arm capture of reel 0.
  - SPIN2, `o_run`=110.
    - On press: go to SPIN1 and arm capture of reel 1.
  - SPIN1, `o_run`=100.
    - On press: go to IDLE and arm capture of reel 2 plus the final judge.
- **Capture:**
  - Capture happens one cycle after the state transition, when the reel's enable is already low and its value is frozen.
  - The armed `o_valN` is loaded from `i_reelN`.
  - For reel 2, the same edge sets `o_win` = (`o_val0`==`o_val1`) and (`o_val1`==`i_reel2`), and pulses `o_done`.
- **Untouched values:** `o_val*` are not cleared on a new game. They keep the previous result until overwritten.
- **Inputs not checked:** digit values are not range-checked. Equality is a plain 4-bit compare.
- **Reset mid-game:** any state goes to IDLE. All outputs return to reset values immediately (asynchronous). A pending capture is dropped.

## Timing

- **Reset values:**
  - `o_run`=000.
  - `o_val0`, `o_val1`, `o_val2` = 0.
  - `o_win`=0, `o_done`=0.
  - State is IDLE.
  - Debounce counter is 0.
- **Key to pulse:** from a clean key transition to the press pulse is 2 (sync) + 2^DEBOUNCE_BITS + 1 cycles.
- **Press to enable change:** press pulse at cycle t; state and `o_run` change at edge t+1.
- **Capture:** `o_valN` updates at edge t+2. `o_win` and `o_done` are valid at edge t+2. `o_done` is high for exactly one cycle.
- **Reel counter contract:** the counter may still advance at edge t+1, because its enable was high during cycle t. Capture at t+2 therefore always matches the frozen reel.
- **Press during a pending capture:** impossible, since press pulses are at least 2^DEBOUNCE_BITS cycles apart. No queuing is required.
- **Bounce rejection:** any glitch shorter than 2^DEBOUNCE_BITS cycles restarts the count and produces no pulse.

## Test plan

Run with `DEBOUNCE_BITS`=3 (8-cycle stability).

- **Reset:** assert `i_rst_n`=0 mid-clock with the key held low → all outputs at reset values. After release, with the key still low, one press is detected at 2+8+1 cycles and state goes to SPIN3, `o_run`=111.
- **Bounce:** toggle `i_key` 0/1 every 3 cycles for 40 cycles, then hold it high → no press pulse, `o_run` stays 000.
- **Full game, win:**
  - Reels driven to 7, 7, 7 at each stop, with four clean presses.
  - `o_run` sequence is 111, 110, 100, 000.
  - `o_val0`/`o_val1`/`o_val2` = 7/7/7.
  - `o_win`=1, with a single-cycle `o_done` two cycles after the fourth press pulse.
- **Full game, lose:**
  - Stops at 3, 3, 4 → `o_win`=0, `o_done` pulses.
  - The next first press clears `o_win`, and the values hold at 3/3/4.
- **Capture race:** the reel model increments on `o_run[0]` at the press edge, going from 5 to 6 → `o_val0`=6, equal to the frozen reel value.
- **Reset mid-game:** assert reset in SPIN2 between the press pulse and the capture edge → state is IDLE, `o_val1` stays 0, `o_done` never pulses.

Source files
------------

// File: rtl/slot_stop_ctrl.sv
// Player key front end for the three-reel slot: sync + debounce the key, step the
// spin/stop FSM on each press, capture each reel one cycle after its enable drops.
module slot_stop_ctrl #(
    parameter int DEBOUNCE_BITS = 20
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_key,
    input  logic [3:0] i_reel0,
    input  logic [3:0] i_reel1,
    input  logic [3:0] i_reel2,
    output logic [2:0] o_run,
    output logic [3:0] o_val0,
    output logic [3:0] o_val1,
    output logic [3:0] o_val2,
    output logic       o_win,
    output logic       o_done
);

    typedef enum logic [1:0] {IDLE, SPIN3, SPIN2, SPIN1} state_t;

    state_t                   state_q, state_d;
    logic                     sync1_q, sync2_q;
    logic                     stable_q, stable_d;
    logic                     stable_dly_q;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
    logic                     press_q, press_d;
    logic [2:0]               cap_q, cap_d;
    logic [3:0]               val0_q, val0_d, val1_q, val1_d, val2_q, val2_d;
    logic                     win_q, win_d;
    logic                     done_q, done_d;

    // Level only moves after the synced key has differed for a full counter wrap.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (&cnt_q) stable_d = sync2_q;
            else        cnt_d    = cnt_q + DEBOUNCE_BITS'(1);
        end
        press_d = stable_dly_q & ~stable_q;
    end

    always_comb begin
        state_d = state_q;
        cap_d   = '0;
        val0_d  = val0_q;
        val1_d  = val1_q;
        val2_d  = val2_q;
        win_d   = win_q;
        done_d  = 1'b0;
        // cap_q is armed at the transition edge, so reels are frozen by now.
        if (cap_q[0]) val0_d = i_reel0;
        if (cap_q[1]) val1_d = i_reel1;
        if (cap_q[2]) begin
            val2_d = i_reel2;
            win_d  = (val0_q == val1_q) && (val1_q == i_reel2);
            done_d = 1'b1;
        end
        case (state_q)
            IDLE:  if (press_q) begin win_d = 1'b0; state_d = SPIN3; end
            SPIN3: if (press_q) begin cap_d = 3'b001; state_d = SPIN2; end
            SPIN2: if (press_q) begin cap_d = 3'b010; state_d = SPIN1; end
            SPIN1: if (press_q) begin cap_d = 3'b100; state_d = IDLE;  end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            SPIN3:   o_run = 3'b111;
            SPIN2:   o_run = 3'b110;
            SPIN1:   o_run = 3'b100;
            default: o_run = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            stable_q     <= 1'b1;
            stable_dly_q <= 1'b1;
            cnt_q        <= '0;
            press_q      <= 1'b0;
            state_q      <= IDLE;
            cap_q        <= '0;
            val0_q       <= '0;
            val1_q       <= '0;
            val2_q       <= '0;
            win_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            sync1_q      <= i_key;
            sync2_q      <= sync1_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            cnt_q        <= cnt_d;
            press_q      <= press_d;
            state_q      <= state_d;
            cap_q        <= cap_d;
            val0_q       <= val0_d;
            val1_q       <= val1_d;
            val2_q       <= val2_d;
            win_q        <= win_d;
            done_q       <= done_d;
        end
    end

    assign o_val0 = val0_q;
    assign o_val1 = val1_q;
    assign o_val2 = val2_q;
    assign o_win  = win_q;
    assign o_done = done_q;

endmodule
